// File: rtl/oh_fifo_arb.sv
// oh_fifo_arb: N independent circular-buffer FIFOs feeding a round-robin
// arbiter and a single registered output stage with valid/wait handshake.
module oh_fifo_arb #(
    parameter int unsigned DW        = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned N         = 4,
    parameter int unsigned PROG_FULL = DEPTH / 2,
    localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      access_in,
    input  logic [N*DW-1:0]   packet_in,
    output logic [N-1:0]      wait_out,
    output logic              access_out,
    output logic [DW-1:0]     packet_out,
    output logic [CW-1:0]     chan_out,
    input  logic              wait_in,
    output logic [N-1:0]      prog_full,
    output logic [N-1:0]      full,
    output logic [N-1:0]      empty,
    output logic [N-1:0]      overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty differ at equal addresses.
    logic [PW-1:0] wr_ptr   [N];
    logic [PW-1:0] rd_ptr   [N];
    logic [PW-1:0] wr_nxt_c [N];
    logic [PW-1:0] rd_nxt_c [N];
    logic [PW-1:0] cnt_nxt_c[N];
    logic [DW-1:0] mem      [N][DEPTH];

    logic [CW-1:0] last_grant;
    logic [CW-1:0] grant_c;
    logic          found_c;
    logic          adv_c;
    logic [N-1:0]  push_c;
    logic [N-1:0]  pop_c;
    logic [AW-1:0] rd_addr_c;
    logic [DW-1:0] head_c;

    assign adv_c    = ~wait_in | ~access_out;
    assign wait_out = prog_full;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int unsigned idx;
        logic [CW-1:0] cand;
        found_c = 1'b0;
        grant_c = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx  = (32'(last_grant) + k) % N;
            cand = CW'(idx);
            if (!found_c && !empty[cand]) begin
                found_c = 1'b1;
                grant_c = cand;
            end
        end
    end

    // Head entry of the granted channel.
    always_comb begin
        rd_addr_c = rd_ptr[grant_c][AW-1:0];
        head_c    = mem[grant_c][rd_addr_c];
    end

    // Push/pop qualification and next-pointer arithmetic per channel.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            push_c[i]    = access_in[i] & ~full[i];
            pop_c[i]     = adv_c & found_c & (grant_c == CW'(i));
            wr_nxt_c[i]  = wr_ptr[i] + PW'(push_c[i]);
            rd_nxt_c[i]  = rd_ptr[i] + PW'(pop_c[i]);
            cnt_nxt_c[i] = wr_nxt_c[i] - rd_nxt_c[i];
        end
    end

    // Pointer registers and status flags registered from next-state counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            empty     <= '1;
            full      <= '0;
            prog_full <= '0;
            overflow  <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                wr_ptr[i]    <= wr_nxt_c[i];
                rd_ptr[i]    <= rd_nxt_c[i];
                empty[i]     <= (cnt_nxt_c[i] == '0);
                full[i]      <= (cnt_nxt_c[i] == PW'(DEPTH));
                prog_full[i] <= (cnt_nxt_c[i] >= PW'(PROG_FULL));
                overflow[i]  <= overflow[i] | (access_in[i] & full[i]);
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (push_c[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= packet_in[i*DW +: DW];
            end
        end
    end

    // Output stage: load on grant, drop valid when nothing is pending, hold under wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            access_out <= 1'b0;
            packet_out <= '0;
            chan_out   <= '0;
            last_grant <= CW'(N - 1);
        end else if (adv_c) begin
            if (found_c) begin
                access_out <= 1'b1;
                packet_out <= head_c;
                chan_out   <= grant_c;
                last_grant <= grant_c;
            end else begin
                access_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oh_fifo_arb.sv
// Directed bench for oh_fifo_arb (N=4, DEPTH=16, DW=64, PROG_FULL=8).
module tb_oh_fifo_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      access_in;
    logic [N*DW-1:0]   packet_in;
    logic [N-1:0]      wait_out;
    logic              access_out;
    logic [DW-1:0]     packet_out;
    logic [CW-1:0]     chan_out;
    logic              wait_in;
    logic [N-1:0]      prog_full;
    logic [N-1:0]      full;
    logic [N-1:0]      empty;
    logic [N-1:0]      overflow;

    int checks = 0;
    int errors = 0;

    oh_fifo_arb #(.DW(64), .DEPTH(16), .N(4), .PROG_FULL(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .access_in  (access_in),
        .packet_in  (packet_in),
        .wait_out   (wait_out),
        .access_out (access_out),
        .packet_out (packet_out),
        .chan_out   (chan_out),
        .wait_in    (wait_in),
        .prog_full  (prog_full),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       acc;
        logic [3:0][15:0] d;
        logic             wi;
        logic             av;
        logic [15:0]      pk;
        logic [1:0]       ch;
        logic [3:0]       em;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample 1ns later.
    task automatic cyc(input logic [3:0] acc, input logic [3:0][15:0] d, input logic wi);
        @(negedge clk);
        access_in = acc;
        wait_in   = wi;
        for (int i = 0; i < int'(N); i++) packet_in[i*DW +: DW] = 64'(d[i]);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " empty"},      64'(empty),      64'hF);
        check({tag, " full"},       64'(full),       64'h0);
        check({tag, " prog_full"},  64'(prog_full),  64'h0);
        check({tag, " wait_out"},   64'(wait_out),   64'h0);
        check({tag, " overflow"},   64'(overflow),   64'h0);
        check({tag, " access_out"}, 64'(access_out), 64'h0);
        check({tag, " packet_out"}, 64'(packet_out), 64'h0);
        check({tag, " chan_out"},   64'(chan_out),   64'h0);
    endtask

    initial begin
        vecs[0]  = '{4'hF, {16'h40, 16'h30, 16'h20, 16'h10}, 1'b0, 1'b0, 16'h00, 2'd0, 4'b0000};
        vecs[1]  = '{4'hF, {16'h41, 16'h31, 16'h21, 16'h11}, 1'b0, 1'b1, 16'h10, 2'd0, 4'b0000};
        vecs[2]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h20, 2'd1, 4'b0000};
        vecs[3]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h30, 2'd2, 4'b0000};
        vecs[4]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h40, 2'd3, 4'b0000};
        vecs[5]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h11, 2'd0, 4'b0001};
        vecs[6]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h21, 2'd1, 4'b0011};
        vecs[7]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h31, 2'd2, 4'b0111};
        vecs[8]  = '{4'h0, 64'h0, 1'b0, 1'b1, 16'h41, 2'd3, 4'b1111};
        vecs[9]  = '{4'h0, 64'h0, 1'b0, 1'b0, 16'h41, 2'd3, 4'b1111};
        vecs[10] = '{4'b0100, {16'h0, 16'hA5, 16'h0, 16'h0}, 1'b0, 1'b0, 16'h41, 2'd3, 4'b1011};
        vecs[11] = '{4'h0, 64'h0, 1'b0, 1'b1, 16'hA5, 2'd2, 4'b1111};
        vecs[12] = '{4'h0, 64'h0, 1'b0, 1'b0, 16'hA5, 2'd2, 4'b1111};

        reset     = 1'b1;
        access_in = '0;
        packet_in = '0;
        wait_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        // Round-robin order, then single-word latency with no bypass.
        for (int v = 0; v < 13; v++) begin
            cyc(vecs[v].acc, vecs[v].d, vecs[v].wi);
            check($sformatf("vec%0d access_out", v), 64'(access_out), 64'(vecs[v].av));
            check($sformatf("vec%0d packet_out", v), packet_out,      64'(vecs[v].pk));
            check($sformatf("vec%0d chan_out", v),   64'(chan_out),   64'(vecs[v].ch));
            check($sformatf("vec%0d empty", v),      64'(empty),      64'(vecs[v].em));
        end

        // Park a ch3 word in the output and hold it with wait_in.
        cyc(4'b1000, {16'hEE, 48'h0}, 1'b1);
        check("park0 access_out", 64'(access_out), 64'h0);
        cyc(4'b0000, 64'h0, 1'b1);
        check("park1 access_out", 64'(access_out), 64'h1);
        check("park1 packet_out", packet_out,      64'hEE);

        // Fill ch0 to full and one beyond while the output stage is stalled.
        for (int k = 0; k < 17; k++) begin
            cyc(4'b0001, {48'h0, 16'h100 + 16'(k)}, 1'b1);
            check($sformatf("fill%0d full0", k),      64'(full[0]),      64'(k >= 15));
            check($sformatf("fill%0d overflow0", k),  64'(overflow[0]),  64'(k >= 16));
            check($sformatf("fill%0d prog_full0", k), 64'(prog_full[0]), 64'(k >= 7));
            check($sformatf("fill%0d hold pkt", k),   packet_out,        64'hEE);
            check($sformatf("fill%0d hold chan", k),  64'(chan_out),     64'd3);
            check($sformatf("fill%0d hold av", k),    64'(access_out),   64'h1);
        end

        // Drain ch0; the push attempted on the first drain cycle hits a full channel.
        cyc(4'b0001, {48'h0, 16'h1FF}, 1'b0);
        check("drain0 packet_out", packet_out,    64'h100);
        check("drain0 chan_out",   64'(chan_out), 64'd0);
        check("drain0 full0",      64'(full[0]),  64'h0);
        for (int k = 1; k < 16; k++) begin
            cyc(4'b0000, 64'h0, 1'b0);
            check($sformatf("drain%0d packet_out", k), packet_out,     64'h100 + 64'(k));
            check($sformatf("drain%0d chan_out", k),   64'(chan_out),  64'd0);
            check($sformatf("drain%0d empty0", k),     64'(empty[0]),  64'(k == 15));
        end
        cyc(4'b0000, 64'h0, 1'b0);
        check("drain_end access_out", 64'(access_out),  64'h0);
        check("drain_end overflow0",  64'(overflow[0]), 64'h1);

        // prog_full threshold on ch1 with output held.
        cyc(4'b1000, {16'hE1, 48'h0}, 1'b1);
        cyc(4'b0000, 64'h0, 1'b1);
        check("pf park packet_out", packet_out,    64'hE1);
        check("pf park chan_out",   64'(chan_out), 64'd3);
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0010, {16'h0, 16'h0, 16'h200 + 16'(k), 16'h0}, 1'b1);
            check($sformatf("pf%0d prog_full1", k), 64'(prog_full[1]), 64'(k == 7));
            check($sformatf("pf%0d wait_out1", k),  64'(wait_out[1]),  64'(k == 7));
            check($sformatf("pf%0d hold pkt", k),   packet_out,        64'hE1);
        end
        cyc(4'b0000, 64'h0, 1'b0);
        check("pf pop packet_out", packet_out,         64'h200);
        check("pf pop chan_out",   64'(chan_out),      64'd1);
        check("pf pop prog_full1", 64'(prog_full[1]),  64'h0);
        check("pf pop wait_out1",  64'(wait_out[1]),   64'h0);

        // Three channels loaded with output valid, then an asynchronous reset.
        cyc(4'b0101, {16'h0, 16'h301, 16'h0, 16'h300}, 1'b1);
        check("pre-rst empty",      64'(empty),      64'b1000);
        check("pre-rst access_out", 64'(access_out), 64'h1);
        @(negedge clk);
        #2;
        reset     = 1'b1;
        access_in = 4'hF;
        #1;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        check("rst-held empty",      64'(empty),      64'hF);
        check("rst-held access_out", 64'(access_out), 64'h0);
        @(negedge clk);
        reset     = 1'b0;
        access_in = '0;
        cyc(4'b0100, {16'h0, 16'h77, 16'h0, 16'h0}, 1'b0);
        check("post-rst e0 access_out", 64'(access_out), 64'h0);
        check("post-rst e0 empty",      64'(empty),      64'b1011);
        cyc(4'b0000, 64'h0, 1'b0);
        check("post-rst e1 access_out", 64'(access_out), 64'h1);
        check("post-rst e1 packet_out", packet_out,      64'h77);
        check("post-rst e1 chan_out",   64'(chan_out),   64'd2);
        cyc(4'b0000, 64'h0, 1'b0);
        check("post-rst e2 access_out", 64'(access_out), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
